wb_stage: RTL and testbench

Writeback stage of the RISC-V pipeline and the writer side of the register file. It latches one instruction per cycle from the MEM stage and selects the result source. It aligns and sign- or zero-extends load data, then drives the register file write port. It also bypasses the in-flight write onto the decode-stage read data and counts retired instructions.

---
 rtl/wb_stage.sv | 143 ++++++++++++++
 tb/tb_wb_stage.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_stage.sv
// Writeback stage: latches the MEM result, selects and extends the write data,
// drives the register file write port, bypasses it to decode, and counts retirements.
module wb_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            MEM_VALID,
    input  logic            STALL,
    input  logic            FLUSH,
    input  logic            MEM_REGWRITE,
    input  logic [4:0]      MEM_RD,
    input  logic [1:0]      MEM_WBSEL,
    input  logic [2:0]      MEM_FUNCT3,
    input  logic [XLEN-1:0] MEM_ALU,
    input  logic [XLEN-1:0] MEM_LOADDATA,
    input  logic [XLEN-1:0] MEM_PC4,
    input  logic [XLEN-1:0] MEM_IMM,
    output logic [XLEN-1:0] RF_IN,
    output logic [4:0]      RF_INADDRESS,
    output logic            RF_WRITE,
    input  logic [4:0]      RS1ADDR,
    input  logic [4:0]      RS2ADDR,
    input  logic [XLEN-1:0] RF_OUT1,
    input  logic [XLEN-1:0] RF_OUT2,
    output logic [XLEN-1:0] RS1DATA,
    output logic [XLEN-1:0] RS2DATA,
    output logic            LOAD_FAULT,
    output logic [63:0]     INSTRET
);

    localparam logic [1:0] SelAlu  = 2'b00;
    localparam logic [1:0] SelLoad = 2'b01;
    localparam logic [1:0] SelPc4  = 2'b10;

    logic            wb_valid_q, wb_valid_d;
    logic            wb_regwrite_q, wb_regwrite_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic [1:0]      wb_wbsel_q, wb_wbsel_d;
    logic [2:0]      wb_funct3_q, wb_funct3_d;
    logic [XLEN-1:0] wb_alu_q, wb_alu_d;
    logic [XLEN-1:0] wb_loaddata_q, wb_loaddata_d;
    logic [XLEN-1:0] wb_pc4_q, wb_pc4_d;
    logic [XLEN-1:0] wb_imm_q, wb_imm_d;
    logic [63:0]     instret_q, instret_d;

    logic            capture;
    logic [1:0]      offset;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_val;
    logic            bad_load;
    logic [XLEN-1:0] result;
    logic            fault;
    logic            rf_write;
    logic            retire;

    always_comb begin
        capture       = MEM_VALID & ~STALL & ~FLUSH;
        wb_valid_d    = capture;
        wb_regwrite_d = capture ? MEM_REGWRITE : wb_regwrite_q;
        wb_rd_d       = capture ? MEM_RD       : wb_rd_q;
        wb_wbsel_d    = capture ? MEM_WBSEL    : wb_wbsel_q;
        wb_funct3_d   = capture ? MEM_FUNCT3   : wb_funct3_q;
        wb_alu_d      = capture ? MEM_ALU      : wb_alu_q;
        wb_loaddata_d = capture ? MEM_LOADDATA : wb_loaddata_q;
        wb_pc4_d      = capture ? MEM_PC4      : wb_pc4_q;
        wb_imm_d      = capture ? MEM_IMM      : wb_imm_q;
        instret_d     = instret_q + {63'b0, retire};
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            wb_rd_q       <= '0;
            wb_wbsel_q    <= '0;
            wb_funct3_q   <= '0;
            wb_alu_q      <= '0;
            wb_loaddata_q <= '0;
            wb_pc4_q      <= '0;
            wb_imm_q      <= '0;
            instret_q     <= '0;
        end else begin
            wb_valid_q    <= wb_valid_d;
            wb_regwrite_q <= wb_regwrite_d;
            wb_rd_q       <= wb_rd_d;
            wb_wbsel_q    <= wb_wbsel_d;
            wb_funct3_q   <= wb_funct3_d;
            wb_alu_q      <= wb_alu_d;
            wb_loaddata_q <= wb_loaddata_d;
            wb_pc4_q      <= wb_pc4_d;
            wb_imm_q      <= wb_imm_d;
            instret_q     <= instret_d;
        end
    end

    // Load lane extraction; offset is the low byte address bits from the ALU.
    always_comb begin
        offset   = wb_alu_q[1:0];
        ld_byte  = wb_loaddata_q[{offset, 3'b000} +: 8];
        ld_half  = offset[1] ? wb_loaddata_q[31:16] : wb_loaddata_q[15:0];
        load_val = wb_loaddata_q;
        bad_load = 1'b0;
        case (wb_funct3_q)
            3'b000: load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100: load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001: begin
                load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
                bad_load = offset[0];
            end
            3'b101: begin
                load_val = {{(XLEN-16){1'b0}}, ld_half};
                bad_load = offset[0];
            end
            3'b010:  bad_load = (offset != 2'b00);
            default: bad_load = 1'b1;
        endcase
    end

    always_comb begin
        case (wb_wbsel_q)
            SelAlu:  result = wb_alu_q;
            SelLoad: result = load_val;
            SelPc4:  result = wb_pc4_q;
            default: result = wb_imm_q;
        endcase
        fault    = wb_valid_q & (wb_wbsel_q == SelLoad) & bad_load;
        // RESET masks the pending write so it is not performed at the resetting edge.
        rf_write = wb_valid_q & wb_regwrite_q & (wb_rd_q != 5'd0) & ~fault & ~RESET;
        retire   = wb_valid_q & ~fault;
    end

    assign RF_IN        = wb_valid_q ? result : '0;
    assign RF_INADDRESS = wb_valid_q ? wb_rd_q : 5'd0;
    assign RF_WRITE     = rf_write;
    assign LOAD_FAULT   = fault;
    assign INSTRET      = instret_q;

    assign RS1DATA = (rf_write && (wb_rd_q == RS1ADDR)) ? RF_IN : RF_OUT1;
    assign RS2DATA = (rf_write && (wb_rd_q == RS2ADDR)) ? RF_IN : RF_OUT2;

endmodule

// File: tb/tb_wb_stage.sv
// Randomized bench for wb_stage against a cycle-level behavioural model,
// preceded by directed scenarios for reset, load extension, bypass and stalls.
module tb_wb_stage;

    logic        CLK, RESET, MEM_VALID, STALL, FLUSH, MEM_REGWRITE;
    logic [4:0]  MEM_RD;
    logic [1:0]  MEM_WBSEL;
    logic [2:0]  MEM_FUNCT3;
    logic [31:0] MEM_ALU, MEM_LOADDATA, MEM_PC4, MEM_IMM;
    logic [31:0] RF_IN;
    logic [4:0]  RF_INADDRESS;
    logic        RF_WRITE;
    logic [4:0]  RS1ADDR, RS2ADDR;
    logic [31:0] RF_OUT1, RF_OUT2, RS1DATA, RS2DATA;
    logic        LOAD_FAULT;
    logic [63:0] INSTRET;

    wb_stage #(.XLEN(32)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_VALID(MEM_VALID), .STALL(STALL), .FLUSH(FLUSH),
        .MEM_REGWRITE(MEM_REGWRITE), .MEM_RD(MEM_RD), .MEM_WBSEL(MEM_WBSEL),
        .MEM_FUNCT3(MEM_FUNCT3), .MEM_ALU(MEM_ALU), .MEM_LOADDATA(MEM_LOADDATA),
        .MEM_PC4(MEM_PC4), .MEM_IMM(MEM_IMM), .RF_IN(RF_IN), .RF_INADDRESS(RF_INADDRESS),
        .RF_WRITE(RF_WRITE), .RS1ADDR(RS1ADDR), .RS2ADDR(RS2ADDR), .RF_OUT1(RF_OUT1),
        .RF_OUT2(RF_OUT2), .RS1DATA(RS1DATA), .RS2DATA(RS2DATA), .LOAD_FAULT(LOAD_FAULT),
        .INSTRET(INSTRET)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst, valid, stall, flush, regwrite;
        logic [4:0]  rd;
        logic [1:0]  wbsel;
        logic [2:0]  f3;
        logic [31:0] alu, ld, pc4, imm;
        logic [4:0]  rs1, rs2;
        logic [31:0] out1, out2;
    } in_t;

    int n_checks, n_pass, n_fail;

    // Model of the instruction sitting in WB and of the retirement count.
    logic        m_valid, m_regwrite;
    logic [4:0]  m_rd;
    logic [1:0]  m_wbsel;
    logic [2:0]  m_f3;
    logic [31:0] m_alu, m_ld, m_pc4, m_imm;
    logic [63:0] m_instret;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Returns {fault, write data} for the modelled WB instruction.
    function automatic logic [32:0] model_result();
        logic [31:0] r, b, h;
        int          off;
        logic        bad;
        off = int'(m_alu[1:0]);
        bad = 1'b0;
        b   = (m_ld >> (8 * off)) & 32'h0000_00FF;
        h   = (m_ld >> (16 * (off / 2))) & 32'h0000_FFFF;
        case (m_wbsel)
            2'd0: r = m_alu;
            2'd2: r = m_pc4;
            2'd3: r = m_imm;
            default: begin
                r = m_ld;
                case (m_f3)
                    3'd0: r = (b > 127) ? b + 32'hFFFF_FF00 : b;
                    3'd4: r = b;
                    3'd1: begin r = (h > 32767) ? h + 32'hFFFF_0000 : h; bad = (off % 2) != 0; end
                    3'd5: begin r = h; bad = (off % 2) != 0; end
                    3'd2: bad = (off != 0);
                    default: bad = 1'b1;
                endcase
            end
        endcase
        if (!m_valid) begin
            r   = '0;
            bad = 1'b0;
        end
        return {bad, r};
    endfunction

    function automatic in_t blank();
        in_t s;
        s = '{rst: 1'b0, valid: 1'b0, stall: 1'b0, flush: 1'b0, regwrite: 1'b0, rd: 5'd0,
              wbsel: 2'd0, f3: 3'd0, alu: '0, ld: '0, pc4: '0, imm: '0, rs1: 5'd31, rs2: 5'd31,
              out1: 32'h1111_0001, out2: 32'h2222_0002};
        return s;
    endfunction

    function automatic in_t rand_in();
        in_t s;
        s.rst      = ($urandom_range(0, 49) == 0);
        s.valid    = ($urandom_range(0, 9) != 0);
        s.stall    = ($urandom_range(0, 7) == 0);
        s.flush    = ($urandom_range(0, 7) == 0);
        s.regwrite = ($urandom_range(0, 3) != 0);
        s.rd       = 5'($urandom_range(0, 7));
        s.wbsel    = 2'($urandom);
        s.f3       = 3'($urandom);
        s.alu      = $urandom;
        s.ld       = $urandom;
        s.pc4      = $urandom;
        s.imm      = $urandom;
        s.rs1      = 5'($urandom_range(0, 7));
        s.rs2      = 5'($urandom_range(0, 7));
        s.out1     = $urandom;
        s.out2     = $urandom;
        return s;
    endfunction

    // Drive one cycle of inputs, check all outputs mid-cycle, then advance the model.
    task automatic step(input in_t s);
        logic [32:0] res;
        logic        wr;
        logic [31:0] e1, e2;
        @(negedge CLK);
        RESET = s.rst; MEM_VALID = s.valid; STALL = s.stall; FLUSH = s.flush;
        MEM_REGWRITE = s.regwrite; MEM_RD = s.rd; MEM_WBSEL = s.wbsel; MEM_FUNCT3 = s.f3;
        MEM_ALU = s.alu; MEM_LOADDATA = s.ld; MEM_PC4 = s.pc4; MEM_IMM = s.imm;
        RS1ADDR = s.rs1; RS2ADDR = s.rs2; RF_OUT1 = s.out1; RF_OUT2 = s.out2;
        #1;
        res = model_result();
        wr  = m_valid && m_regwrite && (m_rd != 5'd0) && !res[32] && !s.rst;
        e1  = (wr && m_rd == s.rs1) ? res[31:0] : s.out1;
        e2  = (wr && m_rd == s.rs2) ? res[31:0] : s.out2;
        check("rf_in", 64'(RF_IN), 64'(res[31:0]));
        check("rf_inaddress", 64'(RF_INADDRESS), 64'(m_valid ? m_rd : 5'd0));
        check("rf_write", 64'(RF_WRITE), 64'(wr));
        check("load_fault", 64'(LOAD_FAULT), 64'(res[32]));
        check("instret", INSTRET, m_instret);
        check("rs1data", 64'(RS1DATA), 64'(e1));
        check("rs2data", 64'(RS2DATA), 64'(e2));
        @(posedge CLK);
        if (s.rst) begin
            m_valid   = 1'b0;
            m_instret = '0;
        end else begin
            if (m_valid && !res[32]) m_instret = m_instret + 64'd1;
            m_valid = s.valid && !s.stall && !s.flush;
            if (m_valid) begin
                m_regwrite = s.regwrite; m_rd = s.rd; m_wbsel = s.wbsel; m_f3 = s.f3;
                m_alu = s.alu; m_ld = s.ld; m_pc4 = s.pc4; m_imm = s.imm;
            end
        end
    endtask

    logic [2:0]  ld_f3   [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
    logic [1:0]  ld_off  [5] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd1};
    logic [31:0] ld_exp  [5] = '{32'hFFFF_FF81, 32'h7F, 32'hFFFF_80F0, 32'h80F0, 32'h0};
    logic        ld_flt  [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        in_t         s;
        logic [63:0] saved;
        n_checks = 0; n_pass = 0; n_fail = 0;
        m_valid = 1'b0; m_regwrite = 1'b0; m_rd = '0; m_wbsel = '0; m_f3 = '0;
        m_alu = '0; m_ld = '0; m_pc4 = '0; m_imm = '0; m_instret = '0;
        s = blank();
        RESET = 1'b1; MEM_VALID = 1'b0; STALL = 1'b0; FLUSH = 1'b0; MEM_REGWRITE = 1'b0;
        MEM_RD = '0; MEM_WBSEL = '0; MEM_FUNCT3 = '0; MEM_ALU = '0; MEM_LOADDATA = '0;
        MEM_PC4 = '0; MEM_IMM = '0; RS1ADDR = '0; RS2ADDR = '0; RF_OUT1 = '0; RF_OUT2 = '0;
        repeat (2) @(posedge CLK);

        // Reset state
        s = blank(); s.rst = 1'b1; s.rs1 = 5'd3; s.out1 = 32'hA5A5_0003;
        step(s);
        #1;
        check("reset_rf_in", 64'(RF_IN), 64'd0);
        check("reset_rf_write", 64'(RF_WRITE), 64'd0);
        check("reset_load_fault", 64'(LOAD_FAULT), 64'd0);
        check("reset_instret", INSTRET, 64'd0);
        check("reset_rs1data", 64'(RS1DATA), 64'h0000_0000_A5A5_0003);

        // Simple ALU write
        s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd5; s.alu = 32'h1234;
        step(s);
        #1;
        check("alu_write", 64'(RF_WRITE), 64'd1);
        check("alu_addr", 64'(RF_INADDRESS), 64'd5);
        check("alu_data", 64'(RF_IN), 64'h1234);
        step(blank());
        #1;
        check("alu_instret", INSTRET, 64'd1);

        // Load extension modes and a misaligned word
        for (int i = 0; i < 5; i++) begin
            s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd9; s.wbsel = 2'b01;
            s.f3 = ld_f3[i]; s.alu = {30'h40, ld_off[i]}; s.ld = 32'h80F0_7F81;
            step(s);
            #1;
            saved = m_instret;
            check("load_fault_flag", 64'(LOAD_FAULT), 64'(ld_flt[i]));
            check("load_write", 64'(RF_WRITE), 64'(!ld_flt[i]));
            if (!ld_flt[i]) check("load_data", 64'(RF_IN), 64'(ld_exp[i]));
        end
        step(blank());
        #1;
        check("fault_not_counted", INSTRET, saved);

        // rd=0 retires without a write; x0 never bypasses
        s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd0; s.wbsel = 2'b10;
        s.pc4 = 32'h40; s.rs1 = 5'd0; s.out1 = 32'h77;
        step(s);
        #1;
        saved = m_instret;
        check("x0_write", 64'(RF_WRITE), 64'd0);
        check("x0_data", 64'(RF_IN), 64'h40);
        check("x0_rs1data", 64'(RS1DATA), 64'h77);
        s = blank(); s.rs1 = 5'd0; s.out1 = 32'h77;
        step(s);
        #1;
        check("x0_instret", INSTRET, saved + 64'd1);

        // Bypass onto RS2
        s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd7; s.alu = 32'hDEAD_BEEF;
        s.rs2 = 5'd7; s.out2 = 32'h11;
        step(s);
        #1;
        check("bypass_hit", 64'(RS2DATA), 64'hDEAD_BEEF);
        RS2ADDR = 5'd8;
        #1;
        check("bypass_miss", 64'(RS2DATA), 64'h11);

        // Stall x3 then flush x1 with a valid instruction held, then release
        step(blank());
        step(blank());
        saved = m_instret;
        for (int i = 0; i < 4; i++) begin
            s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd12; s.alu = 32'hCAFE;
            s.stall = (i < 3); s.flush = (i == 3);
            step(s);
            #1;
            check("stall_no_write", 64'(RF_WRITE), 64'd0);
            check("stall_instret", INSTRET, saved);
        end
        s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd12; s.alu = 32'hCAFE;
        step(s);
        #1;
        check("release_write", 64'(RF_WRITE), 64'd1);
        check("release_data", 64'(RF_IN), 64'hCAFE);
        step(blank());
        #1;
        check("release_single", 64'(RF_WRITE), 64'd0);

        // Reset in the cycle after a capture drops the pending write
        s = blank(); s.valid = 1'b1; s.regwrite = 1'b1; s.rd = 5'd3; s.alu = 32'h33;
        step(s);
        s.rst = 1'b1;
        step(s);
        #1;
        check("midrst_write", 64'(RF_WRITE), 64'd0);
        check("midrst_rf_in", 64'(RF_IN), 64'd0);
        check("midrst_addr", 64'(RF_INADDRESS), 64'd0);
        check("midrst_instret", INSTRET, 64'd0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) step(rand_in());

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
